// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// CRC constants are only consumed when CCFF_READBACK_EN is defined.
package ccff_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      SHIFT  = 3'd2,
      VERIFY = 3'd3,
      DONE   = 3'd4
   } state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // One MSB-first CRC-16 step for a single serial bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16 accumulator with synchronous clear and enable.
// crc_next_o exposes the value including the current input bit.
module ccff_crc16_serial
   import ccff_loader_pkg::*;
(
   input  logic        prog_clk,
   input  logic        prog_reset_n,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc_o,
   output logic [15:0] crc_next_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_next_o = crc16_step(crc_q, din);
      crc_d      = crc_q;
      if (clr) begin
         crc_d = CRC16_INIT;
      end else if (en) begin
         crc_d = crc_next_o;
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serial writer for the tile configuration chain (valid/ready words in, one bit per cycle out).
// Define CCFF_READBACK_EN to add a CRC-checked chain circulation (VERIFY) after each load.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CHAIN_LEN = 22
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int NUM_WORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
   localparam int WL_W      = $clog2(NUM_WORDS + 1);
   localparam int BC_W      = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] REM_ONE     = CNT_W'(1);
   localparam logic [WL_W-1:0]  NUM_WORDS_C = WL_W'(NUM_WORDS);
   localparam logic [WL_W-1:0]  WL_ONE      = WL_W'(1);
   localparam logic [BC_W-1:0]  DATA_W_C    = BC_W'(DATA_W);
   localparam logic [BC_W-1:0]  BC_ONE      = BC_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   rem_bits_q, rem_bits_d;
   logic [WL_W-1:0]    words_left_q, words_left_d;
   logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]  shifter_q, shifter_d;
   logic [DATA_W-1:0]  buf_q, buf_d;
   logic               buf_full_q, buf_full_d;
   logic               error_q, error_d;
   logic               hs;

`ifdef CCFF_READBACK_EN
   logic        crc_clr;
   logic [15:0] crc_wr;
   logic [15:0] crc_rd_next;
   logic [15:0] unused_wr_next;
   logic [15:0] unused_rd_crc;

   assign crc_clr = (state_q == IDLE) && start;

   // Reference CRC over the bits written into the chain head.
   ccff_crc16_serial u_crc_wr (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .clr          (crc_clr),
      .en           (state_q == SHIFT),
      .din          (shifter_q[DATA_W-1]),
      .crc_o        (crc_wr),
      .crc_next_o   (unused_wr_next)
   );

   // Readback CRC over the chain tail while the chain circulates.
   ccff_crc16_serial u_crc_rd (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .clr          (crc_clr),
      .en           (state_q == VERIFY),
      .din          (ccff_tail),
      .crc_o        (unused_rd_crc),
      .crc_next_o   (crc_rd_next)
   );
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

   always_comb begin
      cfg_ready     = 1'b0;
      ccff_shift_en = 1'b0;
      ccff_head     = 1'b0;
      busy          = (state_q != IDLE);
      done          = 1'b0;

      state_d      = state_q;
      rem_bits_d   = rem_bits_q;
      words_left_d = words_left_q;
      bit_cnt_d    = bit_cnt_q;
      shifter_d    = shifter_q;
      buf_d        = buf_q;
      buf_full_d   = buf_full_q;
      error_d      = error_q;

      case (state_q)
         FILL:  cfg_ready = 1'b1;
         SHIFT: begin
            ccff_shift_en = 1'b1;
            ccff_head     = shifter_q[DATA_W-1];
            cfg_ready     = !buf_full_q && (words_left_q != '0);
         end
`ifdef CCFF_READBACK_EN
         VERIFY: begin
            ccff_shift_en = 1'b1;
            ccff_head     = ccff_tail;
         end
`endif
         DONE:    done = 1'b1;
         default: ;
      endcase

      hs = cfg_valid && cfg_ready;
      if (hs) begin
         words_left_d = words_left_q - WL_ONE;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = FILL;
               rem_bits_d   = CHAIN_LEN_C;
               words_left_d = NUM_WORDS_C;
               buf_full_d   = 1'b0;
               error_d      = 1'b0;
            end
         end
         FILL: begin
            if (hs) begin
               shifter_d = cfg_data;
               bit_cnt_d = DATA_W_C;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shifter_d  = shifter_q << 1;
            rem_bits_d = rem_bits_q - REM_ONE;
            bit_cnt_d  = bit_cnt_q - BC_ONE;
            // Last chain bit wins over word end so a partial last word drops its tail.
            if (rem_bits_q == REM_ONE) begin
`ifdef CCFF_READBACK_EN
               state_d    = VERIFY;
               rem_bits_d = CHAIN_LEN_C;
`else
               state_d    = DONE;
`endif
            end else if (bit_cnt_q == BC_ONE) begin
               bit_cnt_d = DATA_W_C;
               if (buf_full_q) begin
                  shifter_d  = buf_q;
                  buf_full_d = 1'b0;
               end else if (hs) begin
                  shifter_d = cfg_data;
               end else begin
                  state_d = FILL;
               end
            end else if (hs) begin
               buf_d      = cfg_data;
               buf_full_d = 1'b1;
            end
         end
`ifdef CCFF_READBACK_EN
         VERIFY: begin
            rem_bits_d = rem_bits_q - REM_ONE;
            if (rem_bits_q == REM_ONE) begin
               state_d = DONE;
               if (crc_rd_next != crc_wr) begin
                  error_d = 1'b1;
               end
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d    = IDLE;
         buf_full_d = 1'b0;
         error_d    = error_q;
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q      <= IDLE;
         rem_bits_q   <= '0;
         words_left_q <= '0;
         bit_cnt_q    <= '0;
         shifter_q    <= '0;
         buf_q        <= '0;
         buf_full_q   <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_bits_q   <= rem_bits_d;
         words_left_q <= words_left_d;
         bit_cnt_q    <= bit_cnt_d;
         shifter_q    <= shifter_d;
         buf_q        <= buf_d;
         buf_full_q   <= buf_full_d;
         error_q      <= error_d;
      end
   end

   assign error = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader with a behavioural chain model on head/tail.
// Readback scenarios run only when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;

   localparam int DATA_W    = 8;
   localparam int CHAIN_LEN = 22;
`ifdef CCFF_READBACK_EN
   localparam int EXP_SHIFTS = 2 * CHAIN_LEN;
`else
   localparam int EXP_SHIFTS = CHAIN_LEN;
`endif

   logic              prog_clk = 1'b0;
   logic              prog_reset_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [DATA_W-1:0] cfg_data = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, error;

   int checks = 0;
   int errors = 0;

   always #5 prog_clk = ~prog_clk;

   // Chain of configuration stages; stuck_mask forces chosen stages to 0.
   logic [CHAIN_LEN-1:0] chain_q = '0;
   logic [CHAIN_LEN-1:0] stuck_mask = '0;
   always @(posedge prog_clk) begin
      if (ccff_shift_en) chain_q <= {chain_q[CHAIN_LEN-2:0], ccff_head} & ~stuck_mask;
   end
   assign ccff_tail = chain_q[CHAIN_LEN-1];

   ccff_chain_loader #(.DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN)) dut (
      .prog_clk      (prog_clk),
      .prog_reset_n  (prog_reset_n),
      .start         (start),
      .abort         (abort),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   logic [DATA_W-1:0]    src_words [4];
   int                   src_n;
   int                   n_shift, hs_cnt, n_done, first_shift, last_shift, done_cyc, fill_cycles;
   logic [CHAIN_LEN-1:0] got;
   logic                 err_at_done, err_after_start, timed_out;
   logic                 post_abort_shift_en, post_abort_busy;
   logic [5:0]           rst_outs;

   // Expected chain stream: words concatenated MSB first, truncated to CHAIN_LEN bits.
   function automatic logic [CHAIN_LEN-1:0] exp_stream();
      logic [CHAIN_LEN-1:0] s;
      s = '0;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         s[CHAIN_LEN-1-i] = src_words[i / DATA_W][DATA_W-1-(i % DATA_W)];
      end
      return s;
   endfunction

   task automatic rand_words(input int n);
      for (int i = 0; i < 4; i++) src_words[i] = DATA_W'($urandom);
      src_n = n;
   endtask

   // Source + observer: start pulse, offer words with gaps, record every chain-bearing cycle.
   task automatic run_load(input int gap, input bit rnd_gap, input int abort_at, input int rst_at);
      int  idx, stall, abort_cyc;
      bit  started;
      idx = 0; stall = 0; started = 0; abort_cyc = -10;
      n_shift = 0; hs_cnt = 0; n_done = 0; first_shift = -1; last_shift = -1; done_cyc = -1;
      fill_cycles = 0; got = '0; err_at_done = 0; err_after_start = 1; timed_out = 1;
      post_abort_shift_en = 1; post_abort_busy = 1; rst_outs = '1;
      for (int c = 0; c < 400; c++) begin
         @(negedge prog_clk);
         start = (c == 0);
         abort = 1'b0;
         if (stall > 0) begin
            cfg_valid = 1'b0;
            stall--;
         end else begin
            cfg_valid = (idx < src_n);
            if (idx < src_n) cfg_data = src_words[idx];
         end
         #1;
         if (busy) started = 1;
         if (c == 1) err_after_start = error;
         if (c == abort_cyc + 1) begin
            post_abort_shift_en = ccff_shift_en;
            post_abort_busy     = busy;
         end
         if (started && !busy) begin
            timed_out = 0;
            break;
         end
         if (cfg_valid && cfg_ready) begin
            hs_cnt++;
            idx++;
            stall = gap + (rnd_gap ? int'($urandom_range(0, 6)) : 0);
         end
         if (ccff_shift_en) begin
            if (n_shift < CHAIN_LEN) got = {got[CHAIN_LEN-2:0], ccff_head};
            if (first_shift < 0) first_shift = c;
            last_shift = c;
            n_shift++;
         end else if (started && cfg_ready) begin
            fill_cycles++;
         end
         if (done) begin
            n_done++;
            done_cyc    = c;
            err_at_done = error;
         end
         if (abort_at >= 0 && ccff_shift_en && n_shift == abort_at) begin
            abort     = 1'b1;
            abort_cyc = c;
         end
         if (rst_at >= 0 && ccff_shift_en && n_shift == rst_at) begin
            prog_reset_n = 1'b0;
            #1;
            rst_outs  = {cfg_ready, ccff_head, ccff_shift_en, busy, done, error};
            timed_out = 0;
            break;
         end
      end
      start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
   endtask

   task automatic check_full_load(input string tag);
      logic [CHAIN_LEN-1:0] exp;
      exp = exp_stream();
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL %s_timeout busy never fell", tag); end
      checks++; if (got !== exp) begin errors++; $display("FAIL %s_stream got=%h exp=%h", tag, got, exp); end
      checks++; if (n_shift != EXP_SHIFTS) begin errors++; $display("FAIL %s_shift_cnt got=%0d exp=%0d", tag, n_shift, EXP_SHIFTS); end
      checks++; if (hs_cnt != 3) begin errors++; $display("FAIL %s_handshakes got=%0d exp=3", tag, hs_cnt); end
      checks++; if (n_done != 1 || done_cyc != last_shift + 1) begin
         errors++; $display("FAIL %s_done count=%0d cyc=%0d exp_cyc=%0d", tag, n_done, done_cyc, last_shift + 1); end
   endtask

   task automatic test_reset();
      prog_reset_n = 1'b0;
      #2;
      checks++; if ({cfg_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0) begin
         errors++; $display("FAIL reset_outs got=%b exp=000000", {cfg_ready, ccff_head, ccff_shift_en, busy, done, error}); end
      repeat (2) @(negedge prog_clk);
      prog_reset_n = 1'b1;
      @(negedge prog_clk); #1;
      checks++; if ({cfg_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0) begin
         errors++; $display("FAIL idle_outs got=%b exp=000000", {cfg_ready, ccff_head, ccff_shift_en, busy, done, error}); end
      $display("reset: outputs checked");
   endtask

   task automatic test_valid_held();
      src_words[0] = 8'hA5; src_words[1] = 8'h3C; src_words[2] = 8'hF0; src_words[3] = 8'h00; src_n = 3;
      run_load(0, 0, -1, -1);
      check_full_load("held");
      checks++; if (last_shift - first_shift + 1 != EXP_SHIFTS) begin
         errors++; $display("FAIL held_bubble span=%0d exp=%0d", last_shift - first_shift + 1, EXP_SHIFTS); end
      checks++; if (fill_cycles != 1) begin errors++; $display("FAIL held_fill got=%0d exp=1", fill_cycles); end
      $display("held: stream=%h shifts=%0d hs=%0d", got, n_shift, hs_cnt);
   endtask

   task automatic test_stall();
      rand_words(3);
      run_load(10, 0, -1, -1);
      check_full_load("stall");
      checks++; if (fill_cycles < 2) begin errors++; $display("FAIL stall_fill got=%0d exp>=2", fill_cycles); end
      checks++; if (last_shift - first_shift + 1 <= EXP_SHIFTS) begin
         errors++; $display("FAIL stall_gap span=%0d exp>%0d", last_shift - first_shift + 1, EXP_SHIFTS); end
      $display("stall: stream=%h fill_cycles=%0d", got, fill_cycles);
   endtask

   task automatic test_extra_word();
      rand_words(4);
      run_load(0, 0, -1, -1);
      check_full_load("extra");
      $display("extra: offered=4 accepted=%0d", hs_cnt);
   endtask

   task automatic test_abort();
      rand_words(3);
      run_load(0, 0, 10, -1);
      checks++; if (post_abort_shift_en !== 1'b0 || post_abort_busy !== 1'b0) begin
         errors++; $display("FAIL abort_next shift_en=%b busy=%b exp=0 0", post_abort_shift_en, post_abort_busy); end
      checks++; if (n_done != 0 || n_shift != 10) begin
         errors++; $display("FAIL abort_counts done=%0d shifts=%0d exp=0 10", n_done, n_shift); end
      $display("abort: stopped after %0d shifts", n_shift);
      rand_words(3);
      run_load(0, 0, -1, -1);
      check_full_load("after_abort");
      $display("after_abort: stream=%h", got);
   endtask

   task automatic test_reset_mid();
      rand_words(3);
      run_load(0, 0, -1, 5);
      checks++; if (rst_outs !== 6'b0) begin errors++; $display("FAIL midreset_outs got=%b exp=000000", rst_outs); end
      repeat (2) @(negedge prog_clk);
      prog_reset_n = 1'b1;
      rand_words(3);
      run_load(0, 0, -1, -1);
      check_full_load("post_reset");
      $display("mid_reset: outs=%b reload stream=%h", rst_outs, got);
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++) begin
         rand_words(3 + int'($urandom_range(0, 1)));
         run_load(0, 1, -1, -1);
         check_full_load("random");
         $display("random[%0d]: stream=%h hs=%0d", t, got, hs_cnt);
      end
   endtask

`ifdef CCFF_READBACK_EN
   task automatic test_readback();
      logic [CHAIN_LEN-1:0] exp;
      stuck_mask = '0;
      rand_words(3);
      run_load(0, 0, -1, -1);
      exp = exp_stream();
      check_full_load("rb_good");
      checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL rb_good_error got=%b exp=0", err_at_done); end
      checks++; if (chain_q !== exp) begin errors++; $display("FAIL rb_chain got=%h exp=%h", chain_q, exp); end
      $display("readback good: chain=%h", chain_q);
      stuck_mask = CHAIN_LEN'(1) << 7;
      src_words[0] = 8'hA5; src_words[1] = 8'h3C; src_words[2] = 8'hF0; src_n = 3;
      run_load(0, 0, -1, -1);
      checks++; if (err_at_done !== 1'b1 || n_done != 1) begin
         errors++; $display("FAIL rb_stuck_error got=%b done=%0d exp=1 1", err_at_done, n_done); end
      $display("readback stuck: error=%b", err_at_done);
      stuck_mask = '0;
      rand_words(3);
      run_load(0, 0, -1, -1);
      checks++; if (err_after_start !== 1'b0 || err_at_done !== 1'b0) begin
         errors++; $display("FAIL rb_clear got=%b/%b exp=0/0", err_after_start, err_at_done); end
      $display("readback clear: error=%b", err_at_done);
   endtask
`endif

   initial begin
      test_reset();
      test_valid_held();
      test_stall();
      test_extra_word();
      test_abort();
      test_reset_mid();
      test_random();
`ifdef CCFF_READBACK_EN
      test_readback();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
